// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M/RV64M multiply/divide unit with valid/ready handshake
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous kill of any accepted or pending operation
//   in_valid     op/a/b valid this cycle
//   in_ready     unit can accept (IDLE only)
//   op           RISC-V funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   a, b         rs1 / rs2 operands
//   out_valid    result valid
//   out_ready    consumer takes the result
//   result       rd value
//   div_by_zero  divide/remainder op had b==0, qualified by out_valid
//   busy         unit is not IDLE
//
// Build option: define MULDIV_EARLY_OUT_EN to finish trivial operations
// (divide by zero, signed overflow, a==0 or b==0) one edge after accept.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nx;
    logic [2:0]         op_q;
    logic               na_q, nb_q, dz_q, early_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvs;
    logic [CW-1:0]      cnt;

    // Operand signedness from funct3: MULH/MULHSU/DIV/REM have signed a,
    // MULH/DIV/REM have signed b.
    logic             sa, sb, na, nb, accept, early;
    logic [WIDTH-1:0] ma, mb;

    assign sa     = op[2] ? ~op[0] : (op[1] ^ op[0]);
    assign sb     = op[2] ? ~op[0] : (op[1:0] == 2'b01);
    assign na     = sa & a[WIDTH-1];
    assign nb     = sb & b[WIDTH-1];
    assign ma     = na ? -a : a;
    assign mb     = nb ? -b : b;
    assign accept = (state == IDLE) && in_valid && !flush;

`ifdef MULDIV_EARLY_OUT_EN
    logic             ovf;
    logic [WIDTH-1:0] early_res;
    assign ovf       = op[2] & ~op[0] & (a == MIN) & (b == '1);
    assign early     = (a == '0) | (b == '0) | ovf;
    assign early_res = !op[2]    ? '0 :
                       (b == '0) ? (op[1] ? a : '1) :
                       ovf       ? (op[1] ? '0 : MIN) : '0;
`else
    assign early = 1'b0;
`endif

    // One iteration. Multiply: acc = {partial product, remaining multiplier bits},
    // add multiplicand on the low bit then shift right. Divide: acc low half holds
    // dividend bits shifting out and quotient bits shifting in.
    logic [WIDTH:0]     hsum, trial, diff;
    logic [2*WIDTH-1:0] acc_nx, prod;
    logic [WIDTH-1:0]   rem_nx, q_s, r_s, fin;

    assign hsum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    assign trial  = {rem, acc[WIDTH-1]};
    assign diff   = trial - {1'b0, dvs};
    assign acc_nx = op_q[2] ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH]}
                            : {hsum, acc[WIDTH-1:1]};
    assign rem_nx = !op_q[2] ? rem : (diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0]);

    // Sign fix-up on the final iteration's values. With b==0 the restoring
    // divider leaves |a| as remainder, so only the quotient needs forcing.
    assign prod = (na_q ^ nb_q) ? -acc_nx : acc_nx;
    assign q_s  = dz_q ? '1 : ((na_q ^ nb_q) ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0]);
    assign r_s  = na_q ? -rem_nx : rem_nx;
    assign fin  = op_q[2] ? (op_q[1] ? r_s : q_s)
                          : ((op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else if (state == IDLE) begin
            state_nx = in_valid ? BUSY : IDLE;
        end else if (state == BUSY) begin
            state_nx = (cnt == '0) ? DONE : BUSY;
        end else begin
            state_nx = out_ready ? IDLE : DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            na_q    <= 1'b0;
            nb_q    <= 1'b0;
            dz_q    <= 1'b0;
            early_q <= 1'b0;
            acc     <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            result  <= '0;
        end else if (accept) begin
            op_q    <= op;
            na_q    <= na;
            nb_q    <= nb;
            dz_q    <= op[2] && (b == '0);
            early_q <= early;
            acc     <= {{WIDTH{1'b0}}, op[2] ? ma : mb};
            rem     <= '0;
            dvs     <= op[2] ? mb : ma;
            cnt     <= early ? '0 : CW'(WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
            result  <= early_res;
`endif
        end else if (state == BUSY) begin
            acc <= acc_nx;
            rem <= rem_nx;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (!early_q) begin
                result <= fin;
            end
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign div_by_zero = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic         clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, div_by_zero, busy;
    logic [W-1:0] result;

    int           n_chk = 0, n_fail = 0;
    logic [W-1:0] m_res = '0;
    logic         m_dz = 1'b0, m_live = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_by_zero(div_by_zero), .busy(busy)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic signed_a(input logic [2:0] o);
        return o inside {3'd1, 3'd2, 3'd4, 3'd6};
    endfunction

    function automatic logic signed_b(input logic [2:0] o);
        return o inside {3'd1, 3'd4, 3'd6};
    endfunction

    // Returns {div_by_zero, result} computed with plain 64-bit arithmetic.
    function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint       sx, sy, p;
        logic [63:0]  pu;
        logic [W-1:0] q, r;
        sx = signed_a(o) ? longint'($signed(x)) : longint'(x);
        sy = signed_b(o) ? longint'($signed(y)) : longint'(y);
        p  = sx * sy;
        pu = p;
        if (!o[2]) return {1'b0, (o == 3'd0) ? pu[31:0] : pu[63:32]};
        if (y == '0) begin
            q = '1;
            r = x;
        end else if (signed_a(o) && x == MIN && y == '1) begin
            q = MIN;
            r = '0;
        end else begin
            q = W'(sx / sy);
            r = W'(sx % sy);
        end
        return {y == '0, o[1] ? r : q};
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if (x == '0 || y == '0 || (o[2] && signed_a(o) && x == MIN && y == '1)) return 1;
`endif
        return W + (o & 3'd0);
    endfunction

    // Output checker: whenever out_valid is high the DUT must show the model's answer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("unexpected_valid", W'(m_live), W'(1'b1));
            check("model_result", result, m_res);
            check("model_dz", W'(div_by_zero), W'(m_dz));
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] lit, input logic lit_dz, input int hold);
        logic [W:0] m;
        int lat;
        m = model(o, x, y);
        check("model_vs_literal", m[W-1:0], lit);
        check("model_dz_literal", W'(m[W]), W'(lit_dz));
        @(negedge clk);
        check("in_ready_idle", W'(in_ready), W'(1'b1));
        op = o; a = x; b = y; in_valid = 1'b1;
        m_res = m[W-1:0]; m_dz = m[W]; m_live = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", W'(lat), W'(exp_latency(o, x, y)));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_in_ready_low", W'(in_ready), W'(1'b0));
            check("hold_valid", W'(out_valid), W'(1'b1));
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = 3'd0; a = 32'd5; b = 32'd5;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        m_live = 1'b0;
        check("valid_dropped", W'(out_valid), W'(1'b0));
        check("no_accept_on_handshake", W'(busy), W'(1'b0));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_out_valid", W'(out_valid), W'(1'b0));
        check("reset_result", result, '0);
        check("reset_dz", W'(div_by_zero), W'(1'b0));
        check("reset_busy", W'(busy), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0);
        do_op(3'd1, MIN,          MIN,           32'h4000_0000, 1'b0, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 1'b0, 0);
        do_op(3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 1'b0, 0);
        do_op(3'd0, 32'd0,        32'h1234_5678, 32'd0,         1'b0, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, 0);
        do_op(3'd4, MIN,          32'hFFFF_FFFF, MIN,           1'b0, 0);
        do_op(3'd6, MIN,          32'hFFFF_FFFF, 32'd0,         1'b0, 0);
        do_op(3'd5, 32'd100,      32'd7,         32'd14,        1'b0, 0);
        do_op(3'd7, 32'd100,      32'd7,         32'd2,         1'b0, 0);
        do_op(3'd5, 32'd10,       32'd0,         32'hFFFF_FFFF, 1'b1, 0);
        do_op(3'd7, 32'd10,       32'd0,         32'd10,        1'b1, 5);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 1'b1, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1'b1, 0);

        // flush together with in_valid must not accept
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_beats_accept", W'(busy), W'(1'b0));

        // flush mid-operation: back to IDLE, and no result ever appears
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("busy_before_flush", W'(busy), W'(1'b1));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", W'(busy), W'(1'b0));
        check("flush_no_valid", W'(out_valid), W'(1'b0));
        repeat (40) @(posedge clk);
        #1;
        check("flush_stays_idle", W'(out_valid), W'(1'b0));

        // async reset mid-operation
        @(negedge clk);
        in_valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", W'(busy), W'(1'b0));
        check("rst_valid", W'(out_valid), W'(1'b0));
        check("rst_result", result, '0);
        check("rst_dz", W'(div_by_zero), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
